// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one single-ported word memory between the
// I-cache (requester 0) and the D-cache (requester 1). Bursts are never
// preempted. Ties go round-robin. Saturating wait counters are kept for perf.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  mwe0,
  input  logic                  mwe1,
  input  logic [ADDR_WIDTH-1:0] maddr0,
  input  logic [ADDR_WIDTH-1:0] maddr1,
  input  logic [DATA_WIDTH-1:0] mdata0,
  input  logic [DATA_WIDTH-1:0] mdata1,
  output logic                  grant0,
  output logic                  grant1,
  output logic [DATA_WIDTH-1:0] mout0,
  output logic [DATA_WIDTH-1:0] mout1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  wait0,
  output logic [CNT_WIDTH-1:0]  wait1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  // 1 means requester 1 was granted most recently, so the next tie goes to 0
  logic   last;

  assign grant0 = (state == OWN0);
  assign grant1 = (state == OWN1);

  // State register and round-robin history; history follows every entry into an OWN state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state == OWN0) last <= 1'b0;
      else if (next_state == OWN1) last <= 1'b1;
    end
  end

  // Next-state: hold while owner requests, hand over directly, else idle
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) next_state = last ? OWN0 : OWN1;
        else if (req0)    next_state = OWN0;
        else if (req1)    next_state = OWN1;
        else              next_state = IDLE;
      end
      OWN0: begin
        if (req0)      next_state = OWN0;
        else if (req1) next_state = OWN1;
        else           next_state = IDLE;
      end
      OWN1: begin
        if (req1)      next_state = OWN1;
        else if (req0) next_state = OWN0;
        else           next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory-side mux: only the owner's signals reach memory; a non-owner's mwe is dropped
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mout0     = '0;
    mout1     = '0;
    unique case (state)
      OWN0: begin
        mem_we    = mwe0;
        mem_addr  = maddr0;
        mem_wdata = mdata0;
        mout0     = mem_rdata;
      end
      OWN1: begin
        mem_we    = mwe1;
        mem_addr  = maddr1;
        mem_wdata = mdata1;
        mout1     = mem_rdata;
      end
      default: ;
    endcase
  end

  // Saturating wait counters: count cycles requesting without holding the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait0 <= '0;
      wait1 <= '0;
    end else begin
      if (req0 && !grant0 && (wait0 != '1)) wait0 <= wait0 + CNT_WIDTH'(1);
      if (req1 && !grant1 && (wait1 != '1)) wait1 <= wait1 + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios then random bursts,
// compared every cycle against an ownership/counter/memory model.
module tb_cache_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int WMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, mwe;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mdata [2];
  logic          grant0, grant1, mem_we;
  logic [DW-1:0] mout0, mout1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] wait0, wait1;

  // memory environment (written by the DUT) and the reference copy
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int owner;   // -1 idle, else requester id
  int last;
  int w [2];
  int total = 0;
  int bad   = 0;
  int burst [2];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(rst),
    .req0(req[0]), .req1(req[1]), .mwe0(mwe[0]), .mwe1(mwe[1]),
    .maddr0(maddr[0]), .maddr1(maddr[1]), .mdata0(mdata[0]), .mdata1(mdata[1]),
    .grant0(grant0), .grant1(grant1), .mout0(mout0), .mout1(mout1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wait0(wait0), .wait1(wait1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1;
    w[0]  = 0;
    w[1]  = 0;
  endtask

  // One clock edge worth of arbitration rules applied to the current inputs
  task automatic model_edge();
    int nxt;
    if (owner >= 0 && mwe[owner]) ref_mem[maddr[owner][7:0]] = mdata[owner];
    for (int n = 0; n < 2; n++)
      if (req[n] && owner != n) w[n] = (w[n] >= WMAX) ? WMAX : w[n] + 1;
    if (owner < 0) begin
      if (req[0] && req[1]) nxt = 1 - last;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
    end else if (req[owner])     nxt = owner;
    else if (req[1 - owner])     nxt = 1 - owner;
    else                         nxt = -1;
    if (nxt >= 0) last = nxt;
    owner = nxt;
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] e_we, e_wd, e_m0, e_m1;
    logic [AW-1:0] e_ad;
    e_we = '0; e_wd = '0; e_ad = '0; e_m0 = '0; e_m1 = '0;
    if (owner >= 0) begin
      e_we = DW'(mwe[owner]);
      e_ad = maddr[owner];
      e_wd = mdata[owner];
      if (owner == 0) e_m0 = ref_mem[maddr[0][7:0]];
      else            e_m1 = ref_mem[maddr[1][7:0]];
    end
    chk({tag, ".grant0"}, 32'(grant0), 32'(owner == 0));
    chk({tag, ".grant1"}, 32'(grant1), 32'(owner == 1));
    chk({tag, ".mem_we"}, 32'(mem_we), e_we);
    chk({tag, ".mem_addr"}, mem_addr, e_ad);
    chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
    chk({tag, ".mout0"}, mout0, e_m0);
    chk({tag, ".mout1"}, mout1, e_m1);
    chk({tag, ".wait0"}, 32'(wait0), 32'(w[0]));
    chk({tag, ".wait1"}, 32'(wait1), 32'(w[1]));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    req = '0; mwe = '0;
    maddr[0] = '0; maddr[1] = '0; mdata[0] = '0; mdata[1] = '0;
  endtask

  // Assert reset away from any clock edge, check, and release before the next edge
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    #2;
    rst = 1'b0;

    // single requester
    req[0] = 1'b1; maddr[0] = 32'h40;
    step("solo");
    chk("solo_grant0", 32'(grant0), 32'd1);
    chk("solo_addr", mem_addr, 32'h40);
    chk("solo_wait0", 32'(wait0), 32'd1);
    req[0] = 1'b0;
    step("solo_drop");

    // first tie after reset goes to 0; handover after 8 owned cycles
    do_reset("rst2");
    req = 2'b11; maddr[1] = 32'h24;
    for (int i = 0; i < 8; i++) step("tie");
    chk("tie_grant0", 32'(grant0), 32'd1);
    req[0] = 1'b0;
    step("handover");
    chk("handover_grant1", 32'(grant1), 32'd1);
    chk("handover_wait1", 32'(wait1), 32'd9);
    req[1] = 1'b0;
    step("handover_end");

    // alternating back-to-back bursts with both requesting
    do_reset("rst3");
    req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 3; i++) begin
        step("alt");
        chk("alt_owner", {31'd0, grant1}, 32'(b % 2));
        chk("alt_nobubble", 32'(grant0 | grant1), 32'd1);
      end
      req[b % 2] = 1'b0;
      step("alt_handover");
      chk("alt_next", {31'd0, grant1}, 32'((b + 1) % 2));
      req[b % 2] = 1'b1;
    end
    req = '0;
    step("alt_end");
    step("alt_idle");

    // non-owner write enable must not reach memory
    do_reset("rst4");
    req[0] = 1'b1; maddr[0] = 32'h10;
    step("safe_grant");
    mwe[1] = 1'b1; maddr[1] = 32'h80; mdata[1] = 32'hDEAD_BEEF;
    #1;
    check_all("safe_comb");
    chk("safe_we", 32'(mem_we), 32'd0);
    step("safe_edge");
    mwe[0] = 1'b1; mdata[0] = 32'h1234_5678;
    step("owner_write");
    chk("safe_mem80", mem[8'h80], ref_mem[8'h80]);
    chk("owner_mem10", mem[8'h10], 32'h1234_5678);
    clear_inputs();
    step("safe_end");

    // async reset in the middle of an OWN1 burst
    req[1] = 1'b1; maddr[1] = 32'h33;
    step("own1");
    mwe[1] = 1'b1; mdata[1] = 32'h5555_AAAA;
    step("own1_b");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("areset_grant1", 32'(grant1), 32'd0);
    chk("areset_we", 32'(mem_we), 32'd0);
    check_all("areset");
    #1;
    rst = 1'b0;
    mwe = '0;
    req = 2'b11;
    step("areset_tie");
    chk("areset_tie_grant0", 32'(grant0), 32'd1);
    clear_inputs();
    step("areset_end");

    // wait1 saturation while requester 0 keeps the memory
    do_reset("rst5");
    req = 2'b11;
    for (int i = 0; i < (1 << CW) + 5; i++) step("sat");
    chk("sat_wait1", 32'(wait1), 32'(WMAX));
    clear_inputs();
    step("sat_end");

    // random bursts
    burst[0] = 0; burst[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[n]   = 1'b1;
            burst[n] = $urandom_range(1, 6);
          end
        end else if (owner == n) begin
          if (burst[n] == 0) req[n] = 1'b0;
          else burst[n]--;
        end else if ($urandom_range(0, 19) == 0) begin
          req[n] = 1'b0;
        end
        mwe[n]   = (owner == n && req[n]) ? 1'($urandom_range(0, 1)) : 1'b0;
        maddr[n] = AW'($urandom_range(0, 255));
        mdata[n] = $urandom;
      end
      #1;
      check_all("rnd_comb");
      step("rnd");
    end
    for (int i = 0; i < 256; i++) chk("rnd_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
